// File: rtl/ps2_keycode_tracker_if.sv
// ----------------------------------------------------------------------------
// ps2_keycode_tracker_if : PS/2 line inputs and key-tracker outputs. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ps2_keycode_tracker_if #(
  parameter int COUNT_W = 8
);
  logic               ps2_clk;
  logic               ps2_data;
  logic [7:0]         keycode;
  logic               key_ext;
  logic [COUNT_W-1:0] key_count;
  logic               new_key;
  logic               frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  keycode, key_ext, key_count, new_key, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output keycode, key_ext, key_count, new_key, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/ps2_keycode_tracker.sv
// ----------------------------------------------------------------------------
// ps2_keycode_tracker : PS/2 frame receiver and make/break/E0 held-key tracker. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ps2_keycode_tracker #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int COUNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   clrn,
  ps2_keycode_tracker_if.slave   bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  logic               clk_s1_q, clk_s2_q, clk_prev_q;
  logic               dat_s1_q, dat_s2_q;
  logic [3:0]         bit_cnt_q;
  logic [9:0]         shift_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [7:0]         byte_q;
  logic               byte_vld_q;
  logic               frame_err_q;
  state_t             state_q, state_d;
  logic [7:0]         keycode_q, keycode_d;
  logic               key_ext_q, key_ext_d;
  logic [COUNT_W-1:0] key_count_q, key_count_d;
  logic               new_key_q, new_key_d;

  logic fall;
  logic last_bit;
  logic frame_ok;
  logic frame_bad;
  logic timeout;
  logic do_make, do_break, ext_flag, match;

  // Synchronisers idle high so a released bus never looks like an edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= bus.ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= bus.ps2_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall     = clk_prev_q & ~clk_s2_q;
  assign last_bit = fall && (bit_cnt_q == 4'd10);
  // shift_q holds start in [0], d0..d7 in [8:1], parity in [9]; stop is live.
  assign frame_ok  = last_bit && !shift_q[0] && dat_s2_q && (^shift_q[9:1]);
  assign frame_bad = last_bit && !frame_ok;
  assign timeout   = (bit_cnt_q != 4'd0) && !fall &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt_q   <= 4'd0;
      shift_q     <= 10'd0;
      tmo_q       <= '0;
      byte_q      <= 8'd0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_vld_q  <= frame_ok;
      frame_err_q <= frame_bad | timeout;
      if (frame_ok) begin
        byte_q <= shift_q[8:1];
      end
      if (fall) begin
        tmo_q <= '0;
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_q <= 4'd0;
        end else begin
          bit_cnt_q <= bit_cnt_q + 4'd1;
          shift_q   <= {dat_s2_q, shift_q[9:1]};
        end
      end else if (timeout) begin
        bit_cnt_q <= 4'd0;
        tmo_q     <= '0;
      end else if (bit_cnt_q != 4'd0) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end else begin
        tmo_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      keycode_q   <= 8'd0;
      key_ext_q   <= 1'b0;
      key_count_q <= '0;
      new_key_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      keycode_q   <= keycode_d;
      key_ext_q   <= key_ext_d;
      key_count_q <= key_count_d;
      new_key_q   <= new_key_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    keycode_d   = keycode_q;
    key_ext_d   = key_ext_q;
    key_count_d = key_count_q;
    new_key_d   = 1'b0;
    do_make     = 1'b0;
    do_break    = 1'b0;
    ext_flag    = 1'b0;
    match       = 1'b0;

    if (timeout) begin
      state_d = IDLE;
    end else if (byte_vld_q) begin
      case (state_q)
        IDLE: begin
          if (byte_q == 8'hF0) begin
            state_d = BRK;
          end else if (byte_q == 8'hE0) begin
            state_d = EXT;
          end else if (!(byte_q inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
            do_make = 1'b1;
          end
        end
        EXT: begin
          if (byte_q == 8'hF0) begin
            state_d = EXT_BRK;
          end else begin
            do_make  = 1'b1;
            ext_flag = 1'b1;
            state_d  = IDLE;
          end
        end
        BRK: begin
          do_break = 1'b1;
          state_d  = IDLE;
        end
        EXT_BRK: begin
          do_break = 1'b1;
          ext_flag = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    match = (byte_q == keycode_q) && (ext_flag == key_ext_q);
    // A make that matches the held key is typematic repeat and is swallowed.
    if (do_make && !match) begin
      keycode_d   = byte_q;
      key_ext_d   = ext_flag;
      key_count_d = key_count_q + COUNT_W'(1);
      new_key_d   = 1'b1;
    end
    if (do_break && match) begin
      keycode_d = 8'd0;
      key_ext_d = 1'b0;
    end
  end

  assign bus.keycode   = keycode_q;
  assign bus.key_ext   = key_ext_q;
  assign bus.key_count = key_count_q;
  assign bus.new_key   = new_key_q;
  assign bus.frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keycode_tracker.sv
// ----------------------------------------------------------------------------
// tb_ps2_keycode_tracker : scoreboard bench with a prefix-flag key model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ps2_keycode_tracker;

  localparam int HALF = 8;
  localparam int TMO  = 300;
  localparam int CW   = 8;

  typedef struct {
    bit          is_err;
    logic [7:0]  kc;
    bit          ext;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk  = 1'b0;
  logic clrn = 1'b0;

  ps2_keycode_tracker_if #(.COUNT_W(CW)) bus ();

  ps2_keycode_tracker #(
    .TIMEOUT_CYCLES(TMO),
    .COUNT_W       (CW)
  ) dut (
    .clk (clk),
    .clrn(clrn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  logic [7:0]    m_kc;
  bit            m_ext;
  logic [CW-1:0] m_cnt;
  bit            m_pre_ext;
  bit            m_pre_brk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: pending E0/F0 prefixes as flags, held key as a plain value.
  task automatic model_byte(input logic [7:0] b);
    if (m_pre_brk) begin
      if (b == m_kc && m_pre_ext == m_ext) begin
        m_kc  = 8'h00;
        m_ext = 1'b0;
      end
      m_pre_brk = 1'b0;
      m_pre_ext = 1'b0;
    end else if (b == 8'hF0) begin
      m_pre_brk = 1'b1;
    end else if (!m_pre_ext && b == 8'hE0) begin
      m_pre_ext = 1'b1;
    end else if (!m_pre_ext && (b == 8'h00 || b == 8'hAA || b == 8'hEE ||
                                b == 8'hFA || b == 8'hFE || b == 8'hFF)) begin
      m_pre_ext = 1'b0;
    end else begin
      if (!(b == m_kc && m_pre_ext == m_ext)) begin
        m_kc  = b;
        m_ext = m_pre_ext;
        m_cnt = m_cnt + CW'(1);
        q.push_back('{1'b0, b, m_pre_ext, m_cnt});
      end
      m_pre_ext = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_kc = 8'h00; m_ext = 1'b0; m_cnt = '0; m_pre_ext = 1'b0; m_pre_brk = 1'b0;
  endtask

  task automatic ps2_bit(input logic d);
    bus.ps2_data = d;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic check_state();
    chk("keycode", 32'(bus.keycode), 32'(m_kc));
    chk("key_ext", 32'(bus.key_ext), 32'(m_ext));
    chk("key_count", 32'(bus.key_count), 32'(m_cnt));
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    if (bad_par || bad_stop) q.push_back('{1'b1, 8'h00, 1'b0, CW'(0)});
    else model_byte(b);
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    bus.ps2_data = 1'b1;
    repeat (12) @(negedge clk);
    check_state();
  endtask

  task automatic sb(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic send_partial_timeout(input int nbits);
    q.push_back('{1'b1, 8'h00, 1'b0, CW'(0)});
    for (int i = 0; i < nbits; i++) ps2_bit(i == 0 ? 1'b0 : 1'($urandom_range(0, 1)));
    bus.ps2_data = 1'b1;
    repeat (TMO + 30) @(negedge clk);
    m_pre_ext = 1'b0;
    m_pre_brk = 1'b0;
    check_state();
  endtask

  task automatic do_reset();
    chk("queue_empty_before_reset", 32'(q.size()), 32'd0);
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    @(negedge clk);
    clrn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Scoreboard monitor: every status pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (clrn) begin
      if (bus.new_key && bus.frame_err) begin
        tests++; fails++;
        $display("FAIL pulse_overlap: new_key=1 frame_err=1, required at most one");
      end else if (bus.new_key || bus.frame_err) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse: new_key=%0b frame_err=%0b, none expected",
                   bus.new_key, bus.frame_err);
        end else begin
          e = q.pop_front();
          if (e.is_err != bus.frame_err ||
              (!e.is_err && (bus.keycode !== e.kc || bus.key_ext !== e.ext ||
                             bus.key_count !== e.cnt))) begin
            fails++;
            $display("FAIL pulse_content: got err=%0b kc=%0h ext=%0b cnt=%0d, expected err=%0b kc=%0h ext=%0b cnt=%0d",
                     bus.frame_err, bus.keycode, bus.key_ext, bus.key_count,
                     e.is_err, e.kc, e.ext, e.cnt);
          end
        end
      end
    end
  end

  logic [7:0] pool [10] = '{8'h1C, 8'h32, 8'h75, 8'h29, 8'hF0, 8'hF0, 8'hE0, 8'hAA, 8'hFA, 8'h5A};

  initial begin
    logic [7:0] b;
    int r;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    #1;
    chk("rst_keycode", 32'(bus.keycode), 32'h0);
    chk("rst_key_ext", 32'(bus.key_ext), 32'h0);
    chk("rst_key_count", 32'(bus.key_count), 32'h0);
    chk("rst_new_key", 32'(bus.new_key), 32'h0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
    @(negedge clk);
    clrn = 1'b1;
    repeat (3) @(negedge clk);

    // Make then break.
    sb(8'h1C);
    chk("tp1_keycode", 32'(bus.keycode), 32'h1C);
    sb(8'hF0); sb(8'h1C);
    chk("tp1_released", 32'(bus.keycode), 32'h00);
    chk("tp1_count", 32'(bus.key_count), 32'd1);

    // Typematic repeat.
    do_reset();
    sb(8'h1C); sb(8'h1C); sb(8'h1C); sb(8'hF0); sb(8'h1C);
    chk("tp2_count", 32'(bus.key_count), 32'd1);
    chk("tp2_keycode", 32'(bus.keycode), 32'h00);

    // Extended key make/break, then plain key of same code.
    do_reset();
    sb(8'hE0); sb(8'h75);
    chk("tp3_ext_kc", 32'(bus.keycode), 32'h75);
    chk("tp3_ext_flag", 32'(bus.key_ext), 32'd1);
    sb(8'hE0); sb(8'hF0); sb(8'h75);
    chk("tp3_rel_kc", 32'(bus.keycode), 32'h00);
    sb(8'hE0); sb(8'h75); sb(8'h75);
    chk("tp3_plain_count", 32'(bus.key_count), 32'd3);
    chk("tp3_plain_ext", 32'(bus.key_ext), 32'd0);

    // Rollover.
    do_reset();
    sb(8'h1C); sb(8'h32); sb(8'hF0); sb(8'h1C);
    chk("tp4_kc", 32'(bus.keycode), 32'h32);
    chk("tp4_count", 32'(bus.key_count), 32'd2);
    sb(8'hF0); sb(8'h32);
    chk("tp4_released", 32'(bus.keycode), 32'h00);

    // Bad parity and bad stop.
    do_reset();
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("tp5_count", 32'(bus.key_count), 32'd0);

    // Partial frame timeout, then a good frame.
    do_reset();
    send_partial_timeout(5);
    sb(8'h29);
    chk("tp6_kc", 32'(bus.keycode), 32'h29);

    // Reset mid-frame while a key is held.
    sb(8'h1C);
    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
    @(negedge clk);
    clrn = 1'b0;
    #1;
    chk("midrst_keycode", 32'(bus.keycode), 32'h0);
    chk("midrst_key_ext", 32'(bus.key_ext), 32'h0);
    chk("midrst_key_count", 32'(bus.key_count), 32'h0);
    chk("midrst_new_key", 32'(bus.new_key), 32'h0);
    chk("midrst_frame_err", 32'(bus.frame_err), 32'h0);
    model_reset();
    bus.ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (3) @(negedge clk);
    sb(8'h29);
    chk("midrst_after_kc", 32'(bus.keycode), 32'h29);
    chk("midrst_after_count", 32'(bus.key_count), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 140; n++) begin
      r = int'($urandom_range(0, 99));
      b = ($urandom_range(0, 4) == 0) ? 8'($urandom()) : pool[$urandom_range(0, 9)];
      if (r < 2) send_partial_timeout(int'($urandom_range(1, 10)));
      else if (r < 8) send_frame(b, 1'b1, 1'b0);
      else if (r < 11) send_frame(b, 1'b0, 1'b1);
      else sb(b);
    end

    repeat (50) @(negedge clk);
    chk("queue_empty_at_end", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps2_keycode_tracker.md
Name: ps2_keycode_tracker

Overview:
- Receives PS/2 keyboard frames and decodes the make/break/extended scan-code protocol.
- Presents the currently held key as an 8-bit keycode; 8'h00 means no key held.
- Drives the two-digit hex keycode display stage directly, and gives the lab top level a press counter and status pulses.

Parameters:
- TIMEOUT_CYCLES, 50000: clk cycles without a ps2_clk falling edge before a partial frame is discarded (1 ms at 50 MHz).
- COUNT_W, 8: width of key_count.

Ports:
- clk  in  1  system clock (50 MHz nominal)
- clrn  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock from the keyboard, asynchronous
- ps2_data  in  1  raw PS/2 data from the keyboard, asynchronous
- keycode  out  8  scan code of the currently held key; 8'h00 when none
- key_ext  out  1  1 when the held key was prefixed by E0
- key_count  out  COUNT_W  number of distinct key presses since reset; wraps
- new_key  out  1  one-cycle pulse when keycode takes a new press
- frame_err  out  1  one-cycle pulse on parity/start/stop error or timeout

Behaviour:
- Reset (clrn=0, asynchronous): all of the following are 0: keycode, key_ext, key_count, new_key, frame_err, the bit counter, the shift register, FSM = IDLE. Synchronizer stages are reset to 1.
- Synchronisation: ps2_clk and ps2_data each pass through 2 flops.
  - A third ps2_clk flop gives the previous value.
  - A falling edge is detected when prev=1 and cur=0.
  - Data is sampled from the synchronised ps2_data in the same cycle.
- Frame: 11 bits = start (0), d0..d7 LSB first, odd parity, stop (1).
  - The bit counter runs 0..10 and returns to 0 after bit 10.
- Frame check at bit 10:
  - The frame is valid only if start=0, stop=1 and XOR(d7..d0, parity)=1.
  - Invalid frame: pulse frame_err, no decode, FSM unchanged.
- Timeout: with the bit counter nonzero, TIMEOUT_CYCLES consecutive cycles without a falling edge do three things: reset the counter to 0, pulse frame_err, and return the FSM to IDLE.
- Latency: a valid byte is registered 1 cycle after the edge detect of bit 10; keycode, key_ext and new_key update on the following cycle (2 cycles after that edge detect).
- Decode FSM, applied per valid byte b:
  - IDLE:
    - b=F0 -> BRK.
    - b=E0 -> EXT.
    - b in {00,AA,EE,FA,FE,FF} -> ignored, stay in IDLE.
    - Any other b is a make code, handled with ext=0.
  - EXT:
    - b=F0 -> EXT_BRK.
    - Any other b is a make code with ext=1 -> IDLE.
  - BRK: b is a break code with ext=0 -> IDLE.
  - EXT_BRK: b is a break code with ext=1 -> IDLE.
- Make code handling:
  - If b == keycode and ext == key_ext, it is typematic repeat: no output change and no pulse.
  - Otherwise set keycode=b and key_ext=ext, pulse new_key, and increment key_count (modulo 2^COUNT_W).
- Break code handling:
  - If b == keycode and ext == key_ext: keycode=00, key_ext=0, no pulse.
  - Otherwise (a break for a non-current key) keycode is unchanged.
- Rollover: pressing a second key while the first is held shows the newest key. Releasing the first key afterwards leaves the newest key displayed.
- Status pulses: new_key and frame_err are never both high in the same cycle. Each is high for exactly 1 clk.
- Reset mid-frame discards the partial frame with no pulses. The first edge after reset is treated as a start bit.

Test Plan:
- Send make 1C, then break F0 1C -> keycode=1C, new_key one pulse, key_count=1; then keycode=00 and key_count stays 1.
- Send 1C three times (typematic), then F0 1C -> exactly one new_key pulse, key_count=1, final keycode=00.
- Send E0 75, then E0 F0 75 -> keycode=75 with key_ext=1, then keycode=00 with key_ext=0; a plain 75 after E0 75 counts as a new press (key_count=2).
- Send 1C then 32 held, then F0 1C -> keycode=32 remains, key_count=2; then F0 32 -> keycode=00.
- Send frame 1C with bad parity, then with stop=0 -> frame_err pulses twice, keycode stays 00, key_count=0.
- Send 5 bits then idle for TIMEOUT_CYCLES -> frame_err pulses; a following full frame 29 decodes to keycode=29. Asserting clrn low mid-frame zeroes all outputs within the same cycle.
